// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard sequencer: tracks break/extended prefixes and modifiers, drives the
// scancode ROM address, post-processes the returned character and queues it for the TTY.
module ps2_key_ctrl #(
   parameter int FIFO_AW = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic [7:0] ascii_data,
   output logic       ascii_valid,
   input  logic       ascii_ready,
   output logic       caps_lock,
   output logic       overflow,
   output logic       scan_lost,
   input  logic       err_clr
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

   typedef enum logic [0:0] {IDLE = 1'b0, LOOKUP = 1'b1} state_t;

   state_t             state_r, state_s;
   logic               brk_r, brk_s, ext_r, ext_s;
   logic               shift_r, shift_s, ctrl_r, ctrl_s, caps_r, caps_s;
   logic [7:0]         rom_addr_r, rom_addr_s;
   logic               overflow_r, overflow_s, scan_lost_r, scan_lost_s;
   logic               push_s, pop_s, drop_s, full_s;
   logic [7:0]         ch_s;
   logic [7:0]         mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [FIFO_AW:0]   count_r;

   // Caps lock inverts letter case (so it composes as XOR with shift), then ctrl folds to 0x00..0x1F.
   function automatic logic [7:0] post_char(input logic [7:0] raw, input logic caps, input logic ctl);
      logic [7:0] c;
      c = raw;
      if (caps && (c >= 8'h61) && (c <= 8'h7A)) begin
         c = c - 8'h20;
      end else if (caps && (c >= 8'h41) && (c <= 8'h5A)) begin
         c = c + 8'h20;
      end else begin
         c = c;
      end
      if (ctl && (c >= 8'h40) && (c <= 8'h7F)) begin
         c = c & 8'h1F;
      end else begin
         c = c;
      end
      return c;
   endfunction

   assign full_s = (count_r == DEPTH_CNT);
   assign pop_s  = (count_r != {(FIFO_AW + 1){1'b0}}) && ascii_ready;
   assign ch_s   = post_char(rom_data, caps_r, ctrl_r);

   // Next-state, byte classification and lookup result handling.
   always_comb begin
      state_s    = state_r;
      brk_s      = brk_r;
      ext_s      = ext_r;
      shift_s    = shift_r;
      ctrl_s     = ctrl_r;
      caps_s     = caps_r;
      rom_addr_s = rom_addr_r;
      push_s     = 1'b0;
      drop_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (!scan_valid) begin
               state_s = IDLE;
            end else if (scan_code == 8'hF0) begin
               brk_s = 1'b1;
            end else if (scan_code == 8'hE0) begin
               ext_s = 1'b1;
            end else begin
               // Every non-prefix byte consumes both pending prefixes.
               brk_s = 1'b0;
               ext_s = 1'b0;
               if (brk_r) begin
                  if ((scan_code == 8'h12) || (scan_code == 8'h59)) begin
                     shift_s = 1'b0;
                  end else if (scan_code == 8'h14) begin
                     ctrl_s = 1'b0;
                  end else begin
                     shift_s = shift_r;
                  end
               end else if ((scan_code == 8'h12) || (scan_code == 8'h59)) begin
                  shift_s = 1'b1;
               end else if (scan_code == 8'h14) begin
                  ctrl_s = 1'b1;
               end else if (scan_code == 8'h58) begin
                  caps_s = !caps_r;
               end else if ((scan_code == 8'h11) || ext_r || scan_code[7]) begin
                  state_s = IDLE;
               end else begin
                  rom_addr_s = {shift_r, scan_code[6:0]};
                  state_s    = LOOKUP;
               end
            end
         end
         LOOKUP: begin
            state_s = IDLE;
            if (ch_s == 8'h00) begin
               push_s = 1'b0;
            end else if (full_s) begin
               drop_s = 1'b1;
            end else begin
               push_s = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      overflow_s  = (overflow_r && !err_clr) || drop_s;
      scan_lost_s = (scan_lost_r && !err_clr) || ((state_r == LOOKUP) && scan_valid);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Modifier flags, ROM address, sticky errors and FIFO bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         brk_r       <= 1'b0;
         ext_r       <= 1'b0;
         shift_r     <= 1'b0;
         ctrl_r      <= 1'b0;
         caps_r      <= 1'b0;
         rom_addr_r  <= 8'h00;
         overflow_r  <= 1'b0;
         scan_lost_r <= 1'b0;
         wr_ptr_r    <= {FIFO_AW{1'b0}};
         rd_ptr_r    <= {FIFO_AW{1'b0}};
         count_r     <= {(FIFO_AW + 1){1'b0}};
      end else begin
         brk_r       <= brk_s;
         ext_r       <= ext_s;
         shift_r     <= shift_s;
         ctrl_r      <= ctrl_s;
         caps_r      <= caps_s;
         rom_addr_r  <= rom_addr_s;
         overflow_r  <= overflow_s;
         scan_lost_r <= scan_lost_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; contents need no reset because occupancy gates the output.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= ch_s;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   assign rom_addr    = rom_addr_r;
   assign ascii_valid = (count_r != {(FIFO_AW + 1){1'b0}});
   assign ascii_data  = ascii_valid ? mem_r[rd_ptr_r] : 8'h00;
   assign caps_lock   = caps_r;
   assign overflow    = overflow_r;
   assign scan_lost   = scan_lost_r;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: directed keystroke scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based keyboard model.
module tb_ps2_key_ctrl;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] scan_code = 8'h00;
   logic       scan_valid = 1'b0;
   logic [7:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] ascii_data;
   logic       ascii_valid;
   logic       ascii_ready = 1'b0;
   logic       caps_lock;
   logic       overflow;
   logic       scan_lost;
   logic       err_clr = 1'b0;

   logic [7:0] rom [256];
   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // Behavioural model state
   logic [7:0] q [$];
   bit m_brk, m_ext, m_shift, m_ctrl, m_caps, m_pend, m_ovf, m_lost;
   logic [7:0] m_addr;

   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   ps2_key_ctrl #(.FIFO_AW(3)) dut (
      .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
      .rom_addr(rom_addr), .rom_data(rom_data), .ascii_data(ascii_data),
      .ascii_valid(ascii_valid), .ascii_ready(ascii_ready), .caps_lock(caps_lock),
      .overflow(overflow), .scan_lost(scan_lost), .err_clr(err_clr)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] xform(input logic [7:0] raw, input bit caps, input bit ctl);
      logic [7:0] c;
      c = raw;
      if (caps && c inside {[8'h61:8'h7A]}) c = c - 8'h20;
      else if (caps && c inside {[8'h41:8'h5A]}) c = c + 8'h20;
      if (ctl && c inside {[8'h40:8'h7F]}) c = c & 8'h1F;
      return c;
   endfunction

   task automatic m_scan(input logic [7:0] c);
      if (c == 8'hF0) m_brk = 1'b1;
      else if (c == 8'hE0) m_ext = 1'b1;
      else begin
         if (m_brk) begin
            if (c == 8'h12 || c == 8'h59) m_shift = 1'b0;
            if (c == 8'h14) m_ctrl = 1'b0;
         end else if (c == 8'h12 || c == 8'h59) m_shift = 1'b1;
         else if (c == 8'h14) m_ctrl = 1'b1;
         else if (c == 8'h58) m_caps = !m_caps;
         else if (!(c == 8'h11 || m_ext || c >= 8'h80)) begin
            m_addr = {m_shift, c[6:0]};
            m_pend = 1'b1;
         end
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   // Model: one keyboard step per clock edge, using the same sampled inputs as the DUT.
   always @(posedge clk) begin
      bit was_pend, full, ovf_ev, lost_ev;
      logic [7:0] ch;
      if (reset) begin
         q.delete();
         {m_brk, m_ext, m_shift, m_ctrl, m_caps, m_pend, m_ovf, m_lost} = 8'h00;
         m_addr = 8'h00;
      end else begin
         was_pend = m_pend;
         ovf_ev = 1'b0;
         lost_ev = 1'b0;
         ch = 8'h00;
         full = (q.size() == DEPTH);
         if (was_pend) begin
            ch = xform(rom[m_addr], m_caps, m_ctrl);
            if (ch != 8'h00 && full) ovf_ev = 1'b1;
         end
         if (ascii_ready && q.size() > 0) void'(q.pop_front());
         if (was_pend && ch != 8'h00 && !full) q.push_back(ch);
         m_pend = 1'b0;
         if (scan_valid) begin
            if (was_pend) lost_ev = 1'b1;
            else m_scan(scan_code);
         end
         m_ovf  = (m_ovf && !err_clr) || ovf_ev;
         m_lost = (m_lost && !err_clr) || lost_ev;
      end
   end

   // Compare: DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rom_addr", rom_addr, m_addr);
         chk("ascii_valid", {7'd0, ascii_valid}, {7'd0, q.size() != 0});
         chk("ascii_data", ascii_data, (q.size() != 0) ? q[0] : 8'h00);
         chk("caps_lock", {7'd0, caps_lock}, {7'd0, m_caps});
         chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
         chk("scan_lost", {7'd0, scan_lost}, {7'd0, m_lost});
      end
   end

   task automatic send(input logic [7:0] c);
      scan_code = c;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic pop_one();
      ascii_ready = 1'b1;
      @(negedge clk);
      ascii_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   function automatic logic [7:0] pick_code();
      case ($urandom_range(0, 9))
         0: return 8'h12;
         1: return 8'h59;
         2: return 8'h14;
         3: return 8'h58;
         4: return 8'hF0;
         5: return 8'hE0;
         6: return 8'($urandom_range(0, 255));
         7: begin
            case ($urandom_range(0, 3))
               0: return 8'h11;
               1: return 8'hAA;
               2: return 8'hFA;
               default: return 8'hFE;
            endcase
         end
         default: return 8'($urandom_range(0, 127));
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) begin
         case ($urandom_range(0, 7))
            0: rom[i] = 8'h00;
            1, 2, 3: rom[i] = 8'($urandom_range(8'h41, 8'h7A));
            default: rom[i] = 8'($urandom_range(1, 255));
         endcase
      end
      rom[8'h1C] = 8'h61;
      rom[8'h9C] = 8'h41;
      rom[8'h15] = 8'h71;
      rom[8'h21] = 8'h63;
      rom[8'h16] = 8'h31;

      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      chk("rst ascii_valid", {7'd0, ascii_valid}, 8'h00);
      chk("rst rom_addr", rom_addr, 8'h00);
      chk("rst flags", {5'd0, caps_lock, overflow, scan_lost}, 8'h00);

      // Single keystroke: address next cycle, character two cycles after strobe.
      scan_code = 8'h1C;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      chk("t1 rom_addr", rom_addr, 8'h1C);
      chk("t1 not yet valid", {7'd0, ascii_valid}, 8'h00);
      @(negedge clk);
      chk("t1 valid", {7'd0, ascii_valid}, 8'h01);
      chk("t1 data", ascii_data, 8'h61);
      pop_one();

      // Shift make/break.
      send(8'h12);
      send(8'h1C);
      chk("t2 shifted addr", rom_addr, 8'h9C);
      send(8'hF0);
      send(8'h12);
      send(8'h1C);
      chk("t2 unshifted addr", rom_addr, 8'h1C);
      chk("t2 head0", ascii_data, 8'h41);
      pop_one();
      chk("t2 head1", ascii_data, 8'h61);
      pop_one();
      chk("t2 empty", {7'd0, ascii_valid}, 8'h00);

      // Caps lock and ctrl.
      send(8'h58);
      chk("t3 caps on", {7'd0, caps_lock}, 8'h01);
      send(8'h15);
      chk("t3 caps char", ascii_data, 8'h51);
      pop_one();
      send(8'h14);
      send(8'h21);
      chk("t3 ctrl char", ascii_data, 8'h03);
      pop_one();
      send(8'hF0);
      send(8'h14);
      send(8'h58);
      chk("t3 caps off", {7'd0, caps_lock}, 8'h00);

      // FIFO overflow, sticky clear, drain.
      repeat (9) send(8'h16);
      chk("t4 overflow", {7'd0, overflow}, 8'h01);
      pulse_clr();
      chk("t4 overflow cleared", {7'd0, overflow}, 8'h00);
      for (int i = 0; i < 8; i++) begin
         chk("t4 drain", ascii_data, 8'h31);
         pop_one();
      end
      chk("t4 drained", {7'd0, ascii_valid}, 8'h00);

      // Extended discard, BAT discard, lost scan.
      send(8'hE0);
      send(8'h75);
      chk("t5 ext discard", {7'd0, ascii_valid}, 8'h00);
      send(8'h1C);
      chk("t5 ext cleared", ascii_data, 8'h61);
      pop_one();
      send(8'hAA);
      chk("t5 bat discard", {7'd0, ascii_valid}, 8'h00);
      scan_code = 8'h1C;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_code = 8'h15;
      @(negedge clk);
      scan_valid = 1'b0;
      chk("t5 scan_lost", {7'd0, scan_lost}, 8'h01);
      @(negedge clk);
      chk("t5 first kept", ascii_data, 8'h61);
      pop_one();
      chk("t5 second lost", {7'd0, ascii_valid}, 8'h00);
      pulse_clr();
      chk("t5 lost cleared", {7'd0, scan_lost}, 8'h00);

      // Reset during lookup.
      repeat (3) send(8'h1C);
      send(8'h58);
      send(8'h12);
      scan_code = 8'h1C;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t6 fifo flushed", {7'd0, ascii_valid}, 8'h00);
      chk("t6 caps cleared", {7'd0, caps_lock}, 8'h00);
      send(8'h1C);
      chk("t6 shift cleared", rom_addr, 8'h1C);
      pop_one();

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         scan_valid  = ($urandom_range(0, 9) < 4);
         scan_code   = pick_code();
         ascii_ready = 1'($urandom_range(0, 1));
         err_clr     = ($urandom_range(0, 19) == 0);
         reset       = ($urandom_range(0, 499) == 0);
      end
      @(negedge clk);
      scan_valid = 1'b0;
      ascii_ready = 1'b0;
      err_clr = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
